// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory line arbiter and the cache
// controllers that talk to it.
//   arb_state_t : arbiter transaction state (IDLE, WB, RD, DONE), 2 bits
//   DMEM_ADDR_W : default line address width
//   DMEM_LINE_W : default line width in bits
//   req_t       : line transaction descriptor built by a cache controller
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 11;
    localparam int DMEM_LINE_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                   wb;
        logic [DMEM_ADDR_W-1:0] wb_addr;
        logic [DMEM_ADDR_W-1:0] fill_addr;
    } req_t;

endpackage : dmem_arb_pkg

// File: rtl/dmem_line_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-requester round-robin picker. When both requesters are
// active, the one that did not own the memory last wins; a lone requester
// always wins. The owner register lives in the parent.
//   req_i        : active requests, bit 0 = CPU0, bit 1 = CPU1
//   last_owner_i : index of the most recent owner
//   pick_o       : one-hot winner, zero when nothing is requested
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic [1:0] pick_o
);

    always_comb begin
        pick_o[0] = req_i[0] & (~req_i[1] |  last_owner_i);
        pick_o[1] = req_i[1] & (~req_i[0] | ~last_owner_i);
    end

endmodule : rr_arb2

// File: rtl/dmem_line_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_line_arbiter
// Shares one line-wide data memory between two cache controllers. A winner is
// picked round-robin in IDLE, its request is captured, and the grant is held
// for the whole transaction: optional victim writeback (WB), line fill (RD),
// then a one-cycle done pulse (DONE). A memory stall longer than TMO_CYC
// cycles aborts the transaction with err alongside done.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   req_x, wb_x                   : request / writeback-needed from CPU x
//   wb_addr_x, wb_line_x          : victim line address and data
//   fill_addr_x                   : line to read
//   grant_x, done_x, err_x        : ownership, completion pulse, timeout flag
//   fill_line                     : last successfully read line
//   mem_addr/re/we/wdata          : data memory request side
//   mem_rdy, mem_rdata            : data memory completion pulse and read data
// -----------------------------------------------------------------------------
module dmem_line_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int LINE_W  = DMEM_LINE_W,
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_0,
    input  logic              req_1,
    input  logic              wb_0,
    input  logic              wb_1,
    input  logic [ADDR_W-1:0] wb_addr_0,
    input  logic [ADDR_W-1:0] wb_addr_1,
    input  logic [LINE_W-1:0] wb_line_0,
    input  logic [LINE_W-1:0] wb_line_1,
    input  logic [ADDR_W-1:0] fill_addr_0,
    input  logic [ADDR_W-1:0] fill_addr_1,
    output logic              grant_0,
    output logic              grant_1,
    output logic              done_0,
    output logic              done_1,
    output logic              err_0,
    output logic              err_1,
    output logic [LINE_W-1:0] fill_line,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_rdy,
    input  logic [LINE_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TMO_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

    arb_state_t        state_q, state_d;
    logic              owner_q;
    logic              last_owner_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [LINE_W-1:0] wb_line_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic [LINE_W-1:0] fill_line_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    logic [1:0]        pick;
    logic              start;
    logic              pick_wb;
    logic              busy;
    logic              tmo_hit;
    logic              enter_phase;

    rr_arb2 u_rr_arb2 (
        .req_i        ({req_1, req_0}),
        .last_owner_i (last_owner_q),
        .pick_o       (pick)
    );

    always_comb begin
        start       = (state_q == IDLE) && (pick != 2'b00);
        pick_wb     = pick[1] ? wb_1 : wb_0;
        busy        = (state_q == WB) || (state_q == RD);
        // Abort on the cycle that would bring the count to TMO_CYC, so the
        // strobe is seen by the memory for exactly TMO_CYC cycles.
        tmo_hit     = busy && !mem_rdy && (cnt_q == CNT_LAST);
        enter_phase = (state_d != state_q) && ((state_d == WB) || (state_d == RD));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = pick_wb ? WB : RD;
                end
            end
            WB: begin
                if (mem_rdy) begin
                    state_d = RD;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end
            end
            RD: begin
                if (mem_rdy || tmo_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        grant_0   = (state_q != IDLE) && !owner_q;
        grant_1   = (state_q != IDLE) &&  owner_q;
        done_0    = (state_q == DONE) && !owner_q;
        done_1    = (state_q == DONE) &&  owner_q;
        err_0     = done_0 && err_q;
        err_1     = done_1 && err_q;
        mem_we    = (state_q == WB);
        mem_re    = (state_q == RD);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == WB) begin
            mem_addr  = wb_addr_q;
            mem_wdata = wb_line_q;
        end else if (state_q == RD) begin
            mem_addr  = fill_addr_q;
        end
        fill_line = fill_line_q;
    end

    // Captured request, ownership and round-robin history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            wb_addr_q    <= '0;
            wb_line_q    <= '0;
            fill_addr_q  <= '0;
        end else begin
            if (start) begin
                owner_q     <= pick[1];
                wb_addr_q   <= pick[1] ? wb_addr_1   : wb_addr_0;
                wb_line_q   <= pick[1] ? wb_line_1   : wb_line_0;
                fill_addr_q <= pick[1] ? fill_addr_1 : fill_addr_0;
            end
            if (state_q == DONE) begin
                last_owner_q <= owner_q;
            end
        end
    end

    // Stall counter, timeout flag and fill data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            err_q       <= 1'b0;
            fill_line_q <= '0;
        end else begin
            if (enter_phase) begin
                cnt_q <= '0;
            end else if (busy && !mem_rdy && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Only meaningful in DONE; any successful path leaves it clear.
            err_q <= tmo_hit;
            if ((state_q == RD) && mem_rdy) begin
                fill_line_q <= mem_rdata;
            end
        end
    end

endmodule : dmem_line_arbiter

// File: tb/tb_dmem_line_arbiter.sv
module tb_dmem_line_arbiter;

    localparam int AW = 11;
    localparam int LW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_0, req_1, wb_0, wb_1;
    logic [AW-1:0] wb_addr_0, wb_addr_1, fill_addr_0, fill_addr_1;
    logic [LW-1:0] wb_line_0, wb_line_1;
    logic          grant_0, grant_1, done_0, done_1, err_0, err_1;
    logic [LW-1:0] fill_line;
    logic [AW-1:0] mem_addr;
    logic          mem_re, mem_we;
    logic [LW-1:0] mem_wdata;
    logic          mem_rdy;
    logic [LW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    dmem_line_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TMO_CYC(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_0       (req_0),
        .req_1       (req_1),
        .wb_0        (wb_0),
        .wb_1        (wb_1),
        .wb_addr_0   (wb_addr_0),
        .wb_addr_1   (wb_addr_1),
        .wb_line_0   (wb_line_0),
        .wb_line_1   (wb_line_1),
        .fill_addr_0 (fill_addr_0),
        .fill_addr_1 (fill_addr_1),
        .grant_0     (grant_0),
        .grant_1     (grant_1),
        .done_0      (done_0),
        .done_1      (done_1),
        .err_0       (err_0),
        .err_1       (err_1),
        .fill_line   (fill_line),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdy     (mem_rdy),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_0 = 0; req_1 = 0; wb_0 = 0; wb_1 = 0;
        wb_addr_0 = '0; wb_addr_1 = '0; wb_line_0 = '0; wb_line_1 = '0;
        fill_addr_0 = '0; fill_addr_1 = '0;
        mem_rdy = 0; mem_rdata = '0;
        step(); step();

        // ---- reset state
        check("rst_grant",  {grant_1, grant_0}, 2'b00);
        check("rst_done",   {done_1, done_0, err_1, err_0}, 4'b0000);
        check("rst_strobe", {mem_re, mem_we}, 2'b00);
        check("rst_fill",   fill_line, 64'h0);
        rst = 1'b0;
        step();

        // ---- single fill, no writeback
        req_0 = 1; wb_0 = 0; fill_addr_0 = 11'h012;
        step();
        check("t1_grant",   {grant_1, grant_0}, 2'b01);
        check("t1_re",      {mem_re, mem_we}, 2'b10);
        check("t1_addr",    mem_addr, 11'h012);
        step();
        check("t1_hold1",   {mem_re, mem_we, mem_addr}, {2'b10, 11'h012});
        step();
        check("t1_hold2",   {mem_re, mem_we, mem_addr}, {2'b10, 11'h012});
        mem_rdy = 1; mem_rdata = 64'hDEAD_BEEF_0123_4567;
        step();
        mem_rdy = 0; mem_rdata = '0;
        check("t1_done",    {done_1, done_0, err_0}, 3'b010);
        check("t1_fill",    fill_line, 64'hDEAD_BEEF_0123_4567);
        check("t1_done_st", {grant_0, mem_re, mem_we}, 3'b100);
        req_0 = 0;
        step();
        check("t1_idle",    {grant_1, grant_0, done_0}, 3'b000);

        // ---- writeback then fill
        req_1 = 1; wb_1 = 1; wb_addr_1 = 11'h040; wb_line_1 = 64'h1111_2222_3333_4444;
        fill_addr_1 = 11'h041;
        step();
        check("t2_grant",   {grant_1, grant_0}, 2'b10);
        check("t2_we",      {mem_re, mem_we, mem_addr}, {2'b01, 11'h040});
        check("t2_wdata",   mem_wdata, 64'h1111_2222_3333_4444);
        wb_addr_1 = 11'h7FF; wb_line_1 = 64'h0;
        step();
        check("t2_we_hold", {mem_re, mem_we, mem_addr}, {2'b01, 11'h040});
        check("t2_wd_hold", mem_wdata, 64'h1111_2222_3333_4444);
        mem_rdy = 1;
        step();
        mem_rdy = 0;
        check("t2_re",      {mem_re, mem_we, mem_addr}, {2'b10, 11'h041});
        mem_rdy = 1; mem_rdata = 64'hCAFE_F00D_5555_AAAA;
        step();
        mem_rdy = 0; mem_rdata = '0;
        check("t2_done",    {done_1, done_0, err_1, mem_re, mem_we}, 5'b10000);
        check("t2_fill",    fill_line, 64'hCAFE_F00D_5555_AAAA);
        req_1 = 0; wb_1 = 0;
        step();
        check("t2_single",  {done_1, grant_1}, 2'b00);

        // ---- simultaneous requests out of reset
        rst = 1; step(); rst = 0; step();
        req_0 = 1; req_1 = 1; fill_addr_0 = 11'h100; fill_addr_1 = 11'h200;
        step();
        check("t3_first",   {grant_1, grant_0, mem_addr}, {2'b01, 11'h100});
        mem_rdy = 1; mem_rdata = 64'hA;
        step();
        mem_rdy = 0;
        check("t3_done0",   {done_1, done_0}, 2'b01);
        step();
        check("t3_gap",     {grant_1, grant_0}, 2'b00);
        step();
        check("t3_second",  {grant_1, grant_0, mem_addr}, {2'b10, 11'h200});
        mem_rdy = 1; mem_rdata = 64'hB;
        step();
        mem_rdy = 0;
        check("t3_done1",   {done_1, done_0}, 2'b10);
        req_1 = 0;
        step();
        check("t3_gap2",    {grant_1, grant_0}, 2'b00);
        step();
        check("t3_third",   {grant_1, grant_0, mem_addr}, {2'b01, 11'h100});
        mem_rdy = 1; mem_rdata = 64'hC;
        step();
        mem_rdy = 0; mem_rdata = '0;
        check("t3_done0b",  {done_0, fill_line}, {1'b1, 64'hC});
        req_0 = 0;
        step();

        // ---- timeout with TMO_CYC = 8
        req_0 = 1; fill_addr_0 = 11'h055; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        check("t4_re0",     {grant_0, mem_re}, 2'b11);
        for (int i = 1; i < 8; i++) begin
            step();
            check("t4_re_hold", {mem_re, done_0}, 2'b10);
        end
        step();
        check("t4_drop",    {mem_re, mem_we}, 2'b00);
        check("t4_done_err", {done_0, err_0, done_1, err_1}, 4'b1100);
        check("t4_fill",    fill_line, 64'hC);
        req_0 = 0; mem_rdata = '0;
        step();
        check("t4_err_pulse", {done_0, err_0}, 2'b00);

        // ---- reset in the middle of RD
        req_1 = 1; fill_addr_1 = 11'h321;
        step();
        check("t5_rd",      {grant_1, mem_re, mem_addr}, {2'b11, 11'h321});
        rst = 1;
        #1;
        check("t5_async",   {grant_1, grant_0, mem_re, mem_we}, 4'b0000);
        check("t5_addr",    mem_addr, 11'h000);
        step();
        rst = 0; req_0 = 1; fill_addr_0 = 11'h077;
        step();
        check("t5_cpu0",    {grant_1, grant_0, mem_addr}, {2'b01, 11'h077});
        mem_rdy = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        step();
        mem_rdy = 0; mem_rdata = '0;
        check("t5_done",    {done_0, fill_line}, {1'b1, 64'h0123_4567_89AB_CDEF});
        req_0 = 0; req_1 = 0;
        step();

        // ---- request churn during RD
        req_0 = 1; fill_addr_0 = 11'h0AA;
        step();
        check("t6_rd",      {mem_re, mem_addr}, {1'b1, 11'h0AA});
        fill_addr_0 = 11'h3FF; req_0 = 0;
        step();
        check("t6_keep",    {grant_0, mem_re, mem_addr}, {2'b11, 11'h0AA});
        mem_rdy = 1; mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
        step();
        mem_rdy = 0; mem_rdata = '0;
        check("t6_done",    {done_0, fill_line}, {1'b1, 64'h5A5A_5A5A_5A5A_5A5A});
        step();
        check("t6_once",    {done_0, grant_0}, 2'b00);
        step();
        check("t6_idle",    {done_0, grant_0, mem_re}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dmem_line_arbiter
